// File: rtl/vec_cmd_issuer.sv
// Single-command initiator for the vector accelerator: latches a host command, issues it,
// waits for done (and read data for reads) under a cycle timeout, and returns one response.
module vec_cmd_issuer #(
  parameter int els_p     = 8,
  parameter int vlen_p    = 4,
  parameter int vdw_p     = 4,
  parameter int timeout_p = 64,
  localparam int v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int vw_lp           = vlen_p * vdw_p,
  localparam int timer_width_lp  = $clog2(timeout_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic [3:0]                 cmd_op_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrA_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrB_i,
  input  logic [v_addr_width_lp-1:0] cmd_addrC_i,
  input  logic [vw_lp-1:0]           cmd_scalar_i,
  input  logic [vw_lp-1:0]           cmd_data_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,

  output logic [3:0]                 acc_op_o,
  output logic [v_addr_width_lp-1:0] acc_addrA_o,
  output logic [v_addr_width_lp-1:0] acc_addrB_o,
  output logic [v_addr_width_lp-1:0] acc_addrC_o,
  output logic [vw_lp-1:0]           acc_scalar_o,
  output logic [vw_lp-1:0]           acc_w_data_o,
  output logic                       acc_v_o,
  input  logic                       acc_ready_i,
  input  logic                       acc_done_i,
  input  logic [vw_lp-1:0]           acc_r_data_i,
  input  logic                       acc_v_i,
  output logic                       acc_yumi_o,

  output logic [3:0]                 resp_op_o,
  output logic [vw_lp-1:0]           resp_data_o,
  output logic                       resp_err_o,
  output logic                       resp_v_o,
  input  logic                       resp_yumi_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0]                op_read_c   = 4'b1000;
  localparam logic [timer_width_lp-1:0] timer_max_c = timer_width_lp'(timeout_p - 1);

  state_e                    state_q;
  logic [timer_width_lp-1:0] timer_q;
  logic                      done_seen_q;
  logic                      data_seen_q;

  logic is_read, in_wait, complete, timed_out;

  assign is_read     = (acc_op_o == op_read_c);
  assign in_wait     = (state_q == WAIT);
  assign cmd_ready_o = (state_q == IDLE);

  // Read data is taken only once per command, and only while the accelerator offers it.
  assign acc_yumi_o = in_wait & is_read & acc_v_i & ~data_seen_q & ~reset_i;

  assign complete  = in_wait & (done_seen_q | acc_done_i)
                   & (~is_read | data_seen_q | acc_yumi_o);
  assign timed_out = in_wait & (timer_q == timer_max_c);

  // The op register doubles as the response op: it is held until the next accept.
  assign resp_op_o = acc_op_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      done_seen_q  <= 1'b0;
      data_seen_q  <= 1'b0;
      acc_op_o     <= '0;
      acc_addrA_o  <= '0;
      acc_addrB_o  <= '0;
      acc_addrC_o  <= '0;
      acc_scalar_o <= '0;
      acc_w_data_o <= '0;
      acc_v_o      <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
      resp_v_o     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_v_i) begin
          acc_op_o     <= cmd_op_i;
          acc_addrA_o  <= cmd_addrA_i;
          acc_addrB_o  <= cmd_addrB_i;
          acc_addrC_o  <= cmd_addrC_i;
          acc_scalar_o <= cmd_scalar_i;
          acc_w_data_o <= cmd_data_i;
          acc_v_o      <= 1'b1;
          resp_data_o  <= '0;
          resp_err_o   <= 1'b0;
          state_q      <= ISSUE;
        end
        ISSUE: if (acc_ready_i) begin
          acc_v_o     <= 1'b0;
          timer_q     <= '0;
          done_seen_q <= 1'b0;
          data_seen_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (acc_done_i) done_seen_q <= 1'b1;
          // resp_data_o is the capture register; it stays 0 for non-read ops.
          if (acc_yumi_o) begin
            data_seen_q <= 1'b1;
            resp_data_o <= acc_r_data_i;
          end
          if (complete) begin
            resp_v_o   <= 1'b1;
            resp_err_o <= 1'b0;
            state_q    <= RESP;
          end else if (timed_out) begin
            resp_v_o    <= 1'b1;
            resp_err_o  <= 1'b1;
            resp_data_o <= '0;
            state_q     <= RESP;
          end
        end
        RESP: if (resp_yumi_i) begin
          resp_v_o <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Directed bench for vec_cmd_issuer: a small accelerator model answers each command and a
// scoreboard monitor checks every consumed response against hand-computed expectations.
module tb_vec_cmd_issuer;

  localparam logic [3:0] OP_READ  = 4'b1000;
  localparam logic [3:0] OP_WRITE = 4'b1001;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDS  = 4'b0100;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  cmd_op_i = '0;
  logic [2:0]  cmd_addrA_i = '0, cmd_addrB_i = '0, cmd_addrC_i = '0;
  logic [15:0] cmd_scalar_i = '0, cmd_data_i = '0;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic [3:0]  acc_op_o;
  logic [2:0]  acc_addrA_o, acc_addrB_o, acc_addrC_o;
  logic [15:0] acc_scalar_o, acc_w_data_o;
  logic        acc_v_o;
  logic        acc_ready_i = 1'b1;
  logic        acc_done_i = 1'b0;
  logic [15:0] acc_r_data_i = '0;
  logic        acc_v_i = 1'b0;
  logic        acc_yumi_o;
  logic [3:0]  resp_op_o;
  logic [15:0] resp_data_o;
  logic        resp_err_o;
  logic        resp_v_o;
  logic        resp_yumi_i = 1'b0;

  vec_cmd_issuer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_op_i(cmd_op_i), .cmd_addrA_i(cmd_addrA_i), .cmd_addrB_i(cmd_addrB_i),
    .cmd_addrC_i(cmd_addrC_i), .cmd_scalar_i(cmd_scalar_i), .cmd_data_i(cmd_data_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .acc_op_o(acc_op_o), .acc_addrA_o(acc_addrA_o), .acc_addrB_o(acc_addrB_o),
    .acc_addrC_o(acc_addrC_o), .acc_scalar_o(acc_scalar_o), .acc_w_data_o(acc_w_data_o),
    .acc_v_o(acc_v_o), .acc_ready_i(acc_ready_i), .acc_done_i(acc_done_i),
    .acc_r_data_i(acc_r_data_i), .acc_v_i(acc_v_i), .acc_yumi_o(acc_yumi_o),
    .resp_op_o(resp_op_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem[8];
  int          last_accept_wait;

  // Values presented on the command port while a response is being held.
  logic        pre_next = 1'b0;
  logic [3:0]  pre_op;
  logic [2:0]  pre_a, pre_b, pre_c;
  logic [15:0] pre_scalar, pre_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] vadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = x[i*4 +: 4] + y[i*4 +: 4];
    return r;
  endfunction

  // Scoreboard monitor: pops one expectation per consumed response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!reset_i && resp_v_o && resp_yumi_i) begin
        if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("resp_op", resp_op_o, e.op);
          check("resp_data", resp_data_o, e.data);
          check("resp_err", resp_err_o, e.err);
        end
      end
    end
  end

  // One command end to end; called and returning on a falling edge.
  // done_dly / data_dly are WAIT-cycle offsets for the model (-1 = never).
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [15:0] scalar, input logic [15:0] data,
                         input int stall, input int done_dly, input int data_dly, input int hold,
                         input logic [15:0] exp_data, input logic exp_err, input int exp_wait);
    int n, k, yc;
    logic taken;
    logic [15:0] rdata;
    exp_t e;
    cmd_op_i = op; cmd_addrA_i = a; cmd_addrB_i = b; cmd_addrC_i = c;
    cmd_scalar_i = scalar; cmd_data_i = data; cmd_v_i = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (n >= 100) check("accept_timeout", 0, 1);
    last_accept_wait = n;
    e.op = op; e.data = exp_data; e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      acc_ready_i = (s == stall);
      if (stall > 0) begin
        check("stall_acc_v", acc_v_o, 1);
        check("stall_fields", {acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_scalar_o, acc_w_data_o},
              {op, a, b, c, scalar, data});
      end
      @(negedge clk_i);
    end
    if (stall > 0) check("single_issue", acc_v_o, 0);
    rdata = 16'h0;
    case (op)
      OP_WRITE: mem[c] = data;
      OP_ADD:   mem[c] = vadd(mem[a], mem[b]);
      OP_ADDS:  mem[c] = vadd(mem[a], scalar);
      OP_READ:  rdata  = mem[a];
      default:  ;
    endcase
    k = 0; yc = 0; taken = 1'b0;
    while (!resp_v_o && k < 200) begin
      acc_done_i   = (k == done_dly);
      acc_v_i      = (data_dly >= 0) && (k >= data_dly) && !taken;
      acc_r_data_i = acc_v_i ? rdata : 16'hDEAD;
      #1;
      if (acc_yumi_o) begin yc++; taken = 1'b1; end
      @(negedge clk_i);
      k++;
    end
    acc_done_i = 1'b0; acc_v_i = 1'b0; acc_r_data_i = 16'h0;
    if (k >= 200) check("resp_timeout", 0, 1);
    if (exp_wait >= 0) check("wait_cycles", k, exp_wait);
    if (data_dly >= 0) check("yumi_pulses", yc, (op == OP_READ) ? 1 : 0);
    if (pre_next) begin
      cmd_op_i = pre_op; cmd_addrA_i = pre_a; cmd_addrB_i = pre_b; cmd_addrC_i = pre_c;
      cmd_scalar_i = pre_scalar; cmd_data_i = pre_data; cmd_v_i = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_resp_v", resp_v_o, 1);
      check("hold_cmd_ready", cmd_ready_o, 0);
      check("hold_fields", {resp_op_o, resp_data_o, resp_err_o}, {op, exp_data, exp_err});
      @(negedge clk_i);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk_i);
    resp_yumi_i = 1'b0;
    pre_next = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_acc_v", acc_v_o, 0);
    check("rst_outputs", {acc_yumi_o, resp_v_o, resp_err_o, resp_data_o, acc_op_o}, 0);

    // Basic sequence; the write also sees acc_v_i, which it must ignore.
    run_cmd(OP_WRITE, 0, 0, 1, 0, 16'h0101, 0, 0, 0, 0, 16'h0, 0, 1);
    run_cmd(OP_WRITE, 0, 0, 2, 0, 16'h1144, 0, 0, -1, 0, 16'h0, 0, 1);
    run_cmd(OP_ADD,   1, 2, 0, 0, 16'h0,    0, 2, -1, 0, 16'h0, 0, 3);
    run_cmd(OP_READ,  0, 0, 0, 0, 16'h0,    0, 0, 2, 0, 16'h1245, 0, 3);
    run_cmd(4'b1111,  0, 0, 0, 16'h7, 16'h9, 0, 1, -1, 0, 16'h0, 0, 2);

    // Issue stalled three cycles by acc_ready_i.
    run_cmd(OP_WRITE, 0, 0, 3, 16'h1234, 16'hBEEF, 3, 0, -1, 0, 16'h0, 0, 1);

    // No done: data is consumed but the timeout response carries zero data.
    run_cmd(OP_READ, 1, 0, 0, 0, 16'h0, 0, -1, 0, 0, 16'h0, 1, 64);
    run_cmd(OP_READ, 3, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'hBEEF, 0, 1);

    // Data before done, then data and done together.
    run_cmd(OP_READ, 1, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0101, 0, 2);
    run_cmd(OP_READ, 2, 0, 0, 0, 16'h0, 0, 1, 1, 0, 16'h1144, 0, 2);

    // Response held five cycles with the next command already waiting.
    pre_next = 1'b1; pre_op = OP_READ; pre_a = 5; pre_b = 0; pre_c = 0;
    pre_scalar = 16'h0; pre_data = 16'h0;
    run_cmd(OP_WRITE, 0, 0, 5, 0, 16'h5A5A, 0, 0, -1, 5, 16'h0, 0, 1);
    run_cmd(OP_READ, 5, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h5A5A, 0, 1);
    check("accept_after_yumi", last_accept_wait, 0);

    // Reset in the middle of a read's WAIT: abort silently.
    cmd_op_i = OP_READ; cmd_addrA_i = 3; cmd_v_i = 1'b1; acc_ready_i = 1'b1;
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    acc_v_i = 1'b1; acc_r_data_i = 16'hBEEF; reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0; acc_v_i = 1'b0;
    check("abort_cmd_ready", cmd_ready_o, 1);
    check("abort_acc_v", acc_v_o, 0);
    check("abort_outputs", {acc_yumi_o, resp_v_o, resp_err_o, resp_data_o, acc_op_o, acc_addrA_o}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("abort_no_resp", resp_v_o, 0);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
